rsa_mm_reader: RTL and testbench
================================

Name: rsa_mm_reader

Overview:
- Avalon-MM pipelined read engine that fetches a contiguous run of 256-bit operand words (key, modulus, message blocks) from DDR3A.
- Delivers the words in order on a valid/ready stream to the RSA datapath.
- Sits directly downstream of the Avalon shell's m0 read port: it drives address/read and consumes readdata/readdatavalid/waitrequest.
- Outstanding reads are credit-limited so returning data can never overflow its internal FIFO.

Parameters:
- ADDR_W, 32, Avalon byte-address width.
- DATA_W, 256, Avalon/stream data width; address stride is DATA_W/8 = 32 bytes.
- LEN_W, 16, width of the word-count field.
- FIFO_DEPTH, 8, return-data FIFO entries (power of 2, min 2).

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  one-cycle command strobe; accepted only in IDLE.
- base_addr  in  ADDR_W  byte address of the first word; sampled with start.
- len  in  LEN_W  number of words to fetch; sampled with start.
- abort  in  1  level; cancels the current job.
- busy  out  1  job in progress.
- done  out  1  one-cycle completion pulse.
- aborted  out  1  valid with done; 1 = job was cancelled.
- avm_address  out  ADDR_W  read address.
- avm_read  out  1  read request.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  DATA_W  returned data.
- avm_readdatavalid  in  1  returned-data qualifier.
- st_data  out  DATA_W  stream word.
- st_valid  out  1  stream word valid.
- st_ready  in  1  consumer accepts the word.
- stall_cycles  out  32  waitrequest stall count (see Optional Feature).

Behaviour:
- Reset values: all outputs 0; all counters 0; FIFO empty; state IDLE.
- States:
  - IDLE -> ISSUE on start with len != 0.
  - IDLE -> DONE on start with len == 0; done pulses the next cycle and no reads are issued.
  - ISSUE -> DRAIN when issued == len_q.
  - DRAIN -> DONE when outstanding == 0, received == len_q and the FIFO is empty.
  - DONE -> IDLE after one cycle. done = 1 only in DONE.
- busy: 1 from the cycle after start acceptance through the DONE cycle.
- start while busy is ignored.
- Credit: credit = FIFO_DEPTH - fifo_count - outstanding.
  - avm_read rises only when in ISSUE, credit > 0, issued < len_q and abort is low.
- Avalon hold rule: once avm_read = 1, it and avm_address stay stable until avm_waitrequest = 0, even if abort rises.
- Acceptance (avm_read & !avm_waitrequest): issued++, outstanding++.
  - Back-to-back reads allowed (no idle cycle required).
- avm_address = base_q + issued * 32, modulo 2^ADDR_W; wrap-around is silent.
- avm_readdatavalid: outstanding--, received++, word pushed into the FIFO.
  - Credit guarantees no overflow; a push while full is a design error (assertion).
- Stream: st_valid = FIFO not empty; st_data = FIFO head (registered, 1-cycle latency from readdatavalid to st_valid).
  - Pop on st_valid & st_ready. Simultaneous push and pop leaves the count unchanged.
  - Order is preserved; st_data is stable while st_valid & !st_ready.
- Abort (ISSUE or DRAIN):
  - No new reads; a held pending read completes its handshake.
  - Returning data is discarded, not pushed; the FIFO is flushed and st_valid drops the next cycle.
  - Go to DONE when outstanding == 0; done pulses with aborted = 1.
  - abort in IDLE has no effect.
- Reset mid-job: immediate return to the reset state. The slave shares the same reset, so no stale readdatavalid is expected.

Optional Feature:
- Macro: RSA_MM_READER_STALL_CNT_EN.
- Defined: stall_cycles increments (saturating at 2^32-1) every cycle with avm_read & avm_waitrequest. It clears on start acceptance and holds after done.
- Undefined: stall_cycles is tied to 0 and the counter logic is absent.

Test Plan:
- base 0x0000_1000, len 4, waitrequest 0, fixed 3-cycle read latency, st_ready 1 -> addresses 0x1000/0x1020/0x1040/0x1060 issued back-to-back; 4 words stream in order; done pulses with aborted = 0.
- len 20, FIFO_DEPTH 8, st_ready held 0 -> at most 8 reads are accepted, then avm_read stays 0. Releasing st_ready lets all 20 words arrive in order; done pulses.
- waitrequest high 5 cycles on the 2nd read -> avm_address is held at base + 0x20 for 5 cycles; stall_cycles = 5 with the macro defined, 0 without.
- base 0xFFFF_FFE0, len 2 -> addresses 0xFFFF_FFE0 then 0x0000_0000.
- len 10, abort raised after 3 accepted reads with 2 outstanding -> no further reads; the 2 returns are dropped; st_valid drops; done pulses with aborted = 1 and busy falls after the DONE cycle.
- start with len 0 -> done pulses the next cycle, avm_read never asserts; a second start while busy is ignored (one done only).

Source files
------------

// File: rtl/rsa_mm_reader.sv
// Avalon-MM pipelined read engine: fetches a run of DATA_W-bit words and replays them in order on a valid/ready stream.
// Optional waitrequest stall counter enabled by defining RSA_MM_READER_STALL_CNT_EN.
module rsa_mm_reader #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 256,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic [31:0]       stall_cycles
);
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int SUM_W     = CNT_W + 1;
    localparam int STRIDE_SH = $clog2(DATA_W / 8);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issued;
    logic [LEN_W-1:0]  received;
    logic [CNT_W-1:0]  outstanding;
    logic              aborting;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;

    logic              accept;
    logic              abort_now;
    logic              kill;
    logic              push;
    logic              pop;
    logic [LEN_W-1:0]  issued_next;
    logic [CNT_W-1:0]  outstanding_next;
    logic [CNT_W-1:0]  count_next;
    logic [SUM_W-1:0]  credit_used;
    logic              can_issue;

    // Once cancelled, returning words are dropped and the FIFO is held empty until DONE.
    assign accept           = avm_read & ~avm_waitrequest;
    assign abort_now        = abort & ((state == S_ISSUE) | (state == S_DRAIN));
    assign kill             = abort_now | aborting;
    assign push             = avm_readdatavalid & ~kill;
    assign pop              = st_valid & st_ready & ~kill;
    assign issued_next      = issued + LEN_W'(accept);
    assign outstanding_next = outstanding + CNT_W'(accept) - CNT_W'(avm_readdatavalid);
    assign count_next       = kill ? '0 : fifo_count + CNT_W'(push) - CNT_W'(pop);
    assign credit_used      = SUM_W'(count_next) + SUM_W'(outstanding_next);
    assign can_issue        = (state == S_ISSUE) && !kill && (issued_next < len_q)
                              && (credit_used < SUM_W'(FIFO_DEPTH));

    assign st_valid = (fifo_count != '0);
    assign st_data  = st_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= avm_readdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            base_q      <= '0;
            len_q       <= '0;
            issued      <= '0;
            received    <= '0;
            outstanding <= '0;
            aborting    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            avm_read    <= 1'b0;
            avm_address <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
        end else begin
            issued      <= issued_next;
            outstanding <= outstanding_next;
            received    <= received + LEN_W'(avm_readdatavalid);
            fifo_count  <= count_next;
            if (kill) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end

            // A stalled request keeps read and address frozen, abort or not.
            if (avm_read && avm_waitrequest) begin
                avm_read <= 1'b1;
            end else if (state == S_IDLE && start && len != '0) begin
                avm_read    <= 1'b1;
                avm_address <= base_addr;
            end else if (can_issue) begin
                avm_read    <= 1'b1;
                avm_address <= base_q + (ADDR_W'(issued_next) << STRIDE_SH);
            end else begin
                avm_read <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q   <= base_addr;
                        len_q    <= len;
                        issued   <= '0;
                        received <= '0;
                        aborting <= 1'b0;
                        busy     <= 1'b1;
                        if (len != '0) begin
                            state <= S_ISSUE;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_ISSUE, S_DRAIN: begin
                    if (abort_now) aborting <= 1'b1;
                    if (kill) begin
                        if (outstanding == '0 && !avm_read) begin
                            state   <= S_DONE;
                            done    <= 1'b1;
                            aborted <= 1'b1;
                        end
                    end else if (state == S_ISSUE) begin
                        if (issued == len_q) state <= S_DRAIN;
                    end else if (outstanding == '0 && received == len_q && fifo_count == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    done     <= 1'b0;
                    aborted  <= 1'b0;
                    busy     <= 1'b0;
                    aborting <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (!reset) !(push && fifo_count == CNT_W'(FIFO_DEPTH)));

`ifdef RSA_MM_READER_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (state == S_IDLE && start) begin
            stall_q <= '0;
        end else if (avm_read && avm_waitrequest && stall_q != '1) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_rsa_mm_reader.sv
// Self-checking bench for rsa_mm_reader: Avalon slave model plus a queue-based model of issued reads and streamed words.
// Respects RSA_MM_READER_STALL_CNT_EN when predicting stall_cycles.
module tb_rsa_mm_reader;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 256;
    localparam int LEN_W  = 16;
    localparam int DEPTH  = 8;
`ifdef RSA_MM_READER_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  len;
    logic              abort;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;
    logic [DATA_W-1:0] st_data;
    logic              st_valid;
    logic              st_ready;
    logic [31:0]       stall_cycles;

    rsa_mm_reader dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len(len),
        .abort(abort), .busy(busy), .done(done), .aborted(aborted),
        .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
        .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int k = 0;
    int done_k = -1;
    bit job_on = 0;
    bit in_done = 0;
    logic [31:0] m_base = '0;
    int m_len = 0, m_issued = 0, m_out = 0, m_pops = 0, stall_m = 0;
    bit m_abort = 0, allow_extra = 0;
    logic [DATA_W-1:0] exp_q [$];
    int rq_due [$];
    logic [DATA_W-1:0] rq_dat [$];
    int last_due = 0;
    logic prev_read = 0, prev_wait = 0;
    logic [31:0] prev_addr = '0;
    logic [31:0] acc_addr [$];
    int acc_k [$];
    int lat_min = 1, lat_max = 1, wr_pct = 0, ready_pct = 100, ready_hold = 0, abort_after = 0, stall_left = 0;
    logic [31:0] stall_target = '0;

    function automatic logic [DATA_W-1:0] word_of(input logic [31:0] a);
        return {a ^ 32'hDEAD_BEEF, a + 32'h1357_9BDF, ~a, {a[15:0], a[31:16]},
                a * 32'd3, a ^ 32'h0F0F_F0F0, a - 32'd7, a};
    endfunction

    function automatic logic [DATA_W-1:0] rand_word();
        logic [DATA_W-1:0] w;
        for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic check(input bit ok, input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_cfg(input int lmin, input int lmax, input int wp, input int rp,
                           input int hold, input int ab, input int sn, input logic [31:0] st);
        lat_min = lmin; lat_max = lmax; wr_pct = wp; ready_pct = rp;
        ready_hold = hold; abort_after = ab; stall_left = sn; stall_target = st;
    endtask

    // Compare DUT outputs against the model at the falling edge, before new inputs are driven.
    task automatic check_output();
        logic [31:0] exp_stall;
        check(busy === job_on, "busy", busy, job_on);
        check(st_valid === (exp_q.size() != 0), "st_valid", st_valid, exp_q.size() != 0);
        if (st_valid === 1'b1 && exp_q.size() != 0) check(st_data === exp_q[0], "st_data", st_data, exp_q[0]);
        if (prev_read && prev_wait)
            check(avm_read === 1'b1 && avm_address === prev_addr, "avalon_hold", {avm_read, avm_address}, {1'b1, prev_addr});
        if (!job_on) begin
            check(done === 1'b0, "done_while_idle", done, 0);
        end else if (done === 1'b1) begin
            in_done = 1;
            done_k  = k;
            exp_stall = STALL_EN ? 32'(stall_m) : 32'h0;
            check(aborted === m_abort, "aborted", aborted, m_abort);
            check(m_out == 0, "outstanding_at_done", m_out, 0);
            check(stall_cycles === exp_stall, "stall_cycles", stall_cycles, exp_stall);
            if (!m_abort) begin
                check(m_pops == m_len, "words_delivered", m_pops, m_len);
                check(m_issued == m_len, "reads_issued", m_issued, m_len);
            end
        end
    endtask

    // One clock cycle: check, drive inputs, then advance the model to the coming rising edge.
    task automatic apply_stimulus(input bit do_start, input logic [31:0] b, input int l);
        bit accept, kill;
        logic [31:0] exp_addr;
        int lat, due;
        @(negedge clk);
        cyc++;
        if (job_on) k++;
        check_output();

        start     = do_start;
        base_addr = b;
        len       = LEN_W'(l);
        if (stall_left > 0 && avm_read && avm_address == stall_target) begin
            avm_waitrequest = 1'b1;
            stall_left--;
        end else begin
            avm_waitrequest = (int'($urandom_range(99)) < wr_pct);
        end
        if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = rq_dat.pop_front();
            void'(rq_due.pop_front());
        end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata      = rand_word();
        end
        st_ready = (k < ready_hold) ? 1'b0 : (int'($urandom_range(99)) < ready_pct);
        abort    = job_on && !in_done && abort_after > 0 && m_issued >= abort_after;

        kill = job_on && !in_done && (abort || m_abort);
        if (kill && !m_abort) begin
            m_abort     = 1;
            allow_extra = avm_read;
        end

        accept = avm_read && !avm_waitrequest;
        if (accept) begin
            exp_addr = m_base + (32'(m_issued) << 5);
            check(job_on == 1, "read_when_idle", 1, 0);
            check(avm_address === exp_addr, "address", avm_address, exp_addr);
            check(m_issued < m_len, "read_count", m_issued, m_len);
            check(m_out + exp_q.size() < DEPTH, "credit", m_out + exp_q.size(), DEPTH - 1);
            if (m_abort) begin
                check(allow_extra, "read_after_abort", 1, 0);
                allow_extra = 0;
            end
            acc_addr.push_back(avm_address);
            acc_k.push_back(k);
            m_issued++;
            m_out++;
            lat = int'($urandom_range(lat_max, lat_min));
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            rq_due.push_back(due);
            rq_dat.push_back(word_of(avm_address));
        end
        if (avm_read && avm_waitrequest) stall_m++;

        if (st_valid && st_ready && !kill && exp_q.size() > 0) begin
            exp_addr = m_base + (32'(m_pops) << 5);
            check(st_data === word_of(exp_addr), "stream_order", st_data, word_of(exp_addr));
            void'(exp_q.pop_front());
            m_pops++;
        end
        if (avm_readdatavalid) begin
            m_out--;
            if (!kill) exp_q.push_back(avm_readdata);
        end
        if (kill) exp_q.delete();

        prev_read = avm_read;
        prev_wait = avm_waitrequest;
        prev_addr = avm_address;

        if (do_start && !job_on) begin
            job_on = 1; k = 0; done_k = -1;
            m_base = b; m_len = l; m_issued = 0; m_pops = 0; stall_m = 0;
            m_abort = 0; allow_extra = 0;
            acc_addr.delete(); acc_k.delete();
        end
        if (in_done) begin
            job_on  = 0;
            in_done = 0;
        end
    endtask

    task automatic run_job(input logic [31:0] b, input int l, input int extra_k);
        apply_stimulus(1'b1, b, l);
        for (int i = 0; i < 4000 && job_on; i++) begin
            if (ready_hold > 0 && k == ready_hold) check(m_issued == DEPTH, "credit_limit", m_issued, DEPTH);
            apply_stimulus(k + 1 == extra_k, 32'h0000_5000, 0);
        end
        if (job_on) begin
            check(1'b0, "job_timeout", k, 0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
        apply_stimulus(1'b0, 32'h0, 0);
        apply_stimulus(1'b0, 32'h0, 0);
    endtask

    initial begin
        int l, ab;
        logic [31:0] b;
        reset = 1'b0; start = 1'b0; base_addr = '0; len = '0; abort = 1'b0;
        avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0; st_ready = 1'b0;
        repeat (3) @(negedge clk);
        check(busy === 1'b0 && done === 1'b0 && aborted === 1'b0, "reset_status", {busy, done, aborted}, 0);
        check(avm_read === 1'b0 && avm_address === '0, "reset_avalon", {avm_read, avm_address}, 0);
        check(st_valid === 1'b0 && st_data === '0, "reset_stream", {st_valid, st_data}, 0);
        check(stall_cycles === 32'h0, "reset_stall", stall_cycles, 0);
        reset = 1'b1;

        set_cfg(3, 3, 0, 100, 0, 0, 0, 32'h0);
        run_job(32'h0000_1000, 4, 0);
        check(acc_addr.size() == 4, "basic_count", acc_addr.size(), 4);
        if (acc_addr.size() == 4) begin
            check(acc_addr[1] === 32'h1020, "basic_addr1", acc_addr[1], 32'h1020);
            check(acc_addr[3] === 32'h1060, "basic_addr3", acc_addr[3], 32'h1060);
            check(acc_k[3] - acc_k[0] == 3, "back_to_back", acc_k[3] - acc_k[0], 3);
        end

        set_cfg(3, 3, 0, 100, 40, 0, 0, 32'h0);
        run_job(32'h0000_8000, 20, 0);
        check(m_pops == 20, "credit_job_words", m_pops, 20);

        set_cfg(1, 1, 0, 100, 0, 0, 5, 32'h0000_2020);
        run_job(32'h0000_2000, 4, 0);
        check(stall_m == 5, "stall_model", stall_m, 5);

        set_cfg(2, 2, 0, 100, 0, 0, 0, 32'h0);
        run_job(32'hFFFF_FFE0, 2, 0);
        check(acc_addr.size() == 2, "wrap_count", acc_addr.size(), 2);
        if (acc_addr.size() == 2) begin
            check(acc_addr[0] === 32'hFFFF_FFE0, "wrap_addr0", acc_addr[0], 32'hFFFF_FFE0);
            check(acc_addr[1] === 32'h0000_0000, "wrap_addr1", acc_addr[1], 0);
        end

        set_cfg(3, 3, 0, 100, 0, 3, 0, 32'h0);
        run_job(32'h0000_4000, 10, 0);
        check(m_abort == 1, "abort_seen", m_abort, 1);
        check(m_issued <= 4, "abort_reads", m_issued, 4);

        set_cfg(1, 1, 0, 100, 0, 0, 0, 32'h0);
        run_job(32'h0000_0100, 0, 1);
        check(done_k == 1, "len0_latency", done_k, 1);
        check(acc_addr.size() == 0, "len0_no_reads", acc_addr.size(), 0);
        run_job(32'h0000_3000, 6, 3);
        check(m_pops == 6, "ignored_start_words", m_pops, 6);

        for (int j = 0; j < 20; j++) begin
            l  = int'($urandom_range(24, 0));
            b  = ($urandom_range(9, 0) == 0) ? 32'hFFFF_FF00 : ($urandom & 32'hFFFF_FFE0);
            ab = (l > 0 && $urandom_range(3, 0) == 0) ? int'($urandom_range(l, 1)) : 0;
            set_cfg(1, int'($urandom_range(6, 1)), int'($urandom_range(40, 0)),
                    int'($urandom_range(100, 30)), 0, ab, 0, 32'h0);
            run_job(b, l, 0);
        end

        repeat (5) apply_stimulus(1'b0, 32'h0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
